// File: rtl/btn_debounce_pkg.sv
// Shared constants and helper functions for the button debounce block.
package btn_pkg;

  // Board clock is 50 MHz, so 50000 cycles gives a 1 ms sample tick.
  localparam int CLK_HZ           = 50_000_000;
  localparam int DEF_TICK_DIV     = 50_000;
  localparam int DEF_STABLE_TICKS = 8;

  // Ceiling log2 that never returns less than 1, so single-entry vectors still get one bit.
  function automatic int clog2_min1(input int val);
    int r;
    r = $clog2(val);
    if (r < 1) begin
      return 1;
    end else begin
      return r;
    end
  endfunction

  // Index of the lowest set bit among the first n bits of vec (0 when none set).
  // Supports up to 32 buttons.
  function automatic int lowest_set(input logic [31:0] vec, input int n);
    int idx;
    idx = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle: raw lines in, debounced levels, edge pulses and press index out.
interface btn_debounce_if
  import btn_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int IDX_W = clog2_min1(N_BTN)
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             press_valid;
  logic [IDX_W-1:0] press_idx;

  // The board/stimulus side drives the raw lines and consumes the cleaned outputs.
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, press_valid, press_idx
  );

  // The debouncer consumes the raw lines and produces the cleaned outputs.
  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, press_valid, press_idx
  );
endinterface

// File: rtl/btn_debounce_cell.sv
// One button: two-flop synchronizer, tick-driven stable counter, level and edge pulses.
module btn_debounce_cell
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
)(
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_press_nxt
);

  localparam int               CNT_W    = clog2_min1(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic             r_release;
  logic             w_mismatch;
  logic             w_rise;
  logic             w_fall;

  // Mismatch between synchronized input and accepted level, plus level edge detect.
  always_comb begin
    w_mismatch = r_sync2 ^ r_level;
    w_rise     = r_level & ~r_level_d;
    w_fall     = ~r_level & r_level_d;
  end

  // Bring the asynchronous raw line into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Qualify a level change over STABLE_TICKS consecutive mismatching ticks; any agreeing tick restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (i_tick) begin
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt   <= r_cnt;
      r_level <= r_level;
    end
  end

  // Registered one-cycle pulses the cycle after the accepted level changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  assign o_level     = r_level;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_press_nxt = w_rise;

endmodule

// File: rtl/btn_debounce.sv
// Multi-button debouncer: shared sample prescaler, per-button cells, press index encoder.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int IDX_W        = clog2_min1(N_BTN)
)(
  input  logic           clk,
  input  logic           rst,
  btn_debounce_if.slave  bus
);

  localparam int               PRE_W     = clog2_min1(TICK_DIV);
  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic             w_tick;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [N_BTN-1:0] w_press_nxt;
  logic             w_any_press;
  logic [IDX_W-1:0] w_idx;
  logic             r_press_valid;
  logic [IDX_W-1:0] r_press_idx;

  // Tick on the last prescaler count; encode the lowest button about to pulse press.
  always_comb begin
    w_tick      = (r_pre_cnt == TICK_LAST);
    w_any_press = |w_press_nxt;
    w_idx       = IDX_W'(lowest_set(32'(w_press_nxt), N_BTN));
  end

  // Free-running prescaler 0..TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_cell
      btn_debounce_cell #(
        .STABLE_TICKS (STABLE_TICKS)
      ) u_cell (
        .clk         (clk),
        .rst         (rst),
        .i_raw       (bus.btn_raw[gi]),
        .i_tick      (w_tick),
        .o_level     (w_level[gi]),
        .o_press     (w_press[gi]),
        .o_release   (w_release[gi]),
        .o_press_nxt (w_press_nxt[gi])
      );
    end
  endgenerate

  // Press summary registered alongside the per-button press pulses; index held between presses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_press_valid <= 1'b0;
      r_press_idx   <= '0;
    end else begin
      r_press_valid <= w_any_press;
      if (w_any_press) begin
        r_press_idx <= w_idx;
      end else begin
        r_press_idx <= r_press_idx;
      end
    end
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.press_valid = r_press_valid;
  assign bus.press_idx   = r_press_idx;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with TICK_DIV=4, STABLE_TICKS=3, N_BTN=4.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  btn_debounce_if #(.N_BTN(4), .IDX_W(2)) bif ();
  btn_debounce_if #(.N_BTN(4), .IDX_W(2)) bif1 ();

  btn_debounce #(.N_BTN(4), .TICK_DIV(4), .STABLE_TICKS(3), .IDX_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  btn_debounce #(.N_BTN(4), .TICK_DIV(1), .STABLE_TICKS(3), .IDX_W(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bif1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n     = 0;
  logic [3:0] seen_press;
  logic [3:0] seen_rel;
  logic       seen_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    seen_press |= bif.btn_press;
    seen_rel   |= bif.btn_release;
    seen_valid |= bif.press_valid;
  endtask

  task automatic clr_seen();
    seen_press = 4'b0000;
    seen_rel   = 4'b0000;
    seen_valid = 1'b0;
  endtask

  task automatic wait_level(input logic [3:0] mask, input logic [3:0] want, input int maxc,
                            output int cnt);
    cnt = 0;
    while (((bif.btn_level & mask) != want) && (cnt < maxc)) begin
      step();
      cnt++;
    end
    chk("wait_level", 32'(bif.btn_level & mask), 32'(want));
  endtask

  initial begin
    bif.btn_raw  = 4'b0000;
    bif1.btn_raw = 4'b0000;
    clr_seen();
    rst = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_level",   32'(bif.btn_level),   32'h0);
    chk("rst_press",   32'(bif.btn_press),   32'h0);
    chk("rst_release", 32'(bif.btn_release), 32'h0);
    chk("rst_valid",   32'(bif.press_valid), 32'h0);
    chk("rst_idx",     32'(bif.press_idx),   32'h0);

    // Prescaler: tick visible after steps 3, 7, 11; TICK_DIV=1 ticks every cycle
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("tick", 32'(dut.w_tick), 32'((cyc % 4) == 3));
      if (k < 4) begin
        chk("tick_div1", 32'(dut1.w_tick), 32'h1);
      end
    end

    // Clean press on btn2: level within 11..14 cycles, one press pulse
    clr_seen();
    bif.btn_raw = 4'b0100;
    wait_level(4'b0100, 4'b0100, 30, n);
    chk("press_lat", 32'((n >= 11) && (n <= 14)), 32'h1);
    chk("press_early_pulse", 32'({seen_press, seen_rel}), 32'h0);
    step();
    chk("press_pulse", 32'(bif.btn_press),   32'h4);
    chk("press_valid", 32'(bif.press_valid), 32'h1);
    chk("press_idx2",  32'(bif.press_idx),   32'h2);
    chk("press_norel", 32'(bif.btn_release), 32'h0);
    step();
    chk("press_once",  32'(bif.btn_press),   32'h0);
    chk("press_vdrop", 32'(bif.press_valid), 32'h0);
    chk("press_hold",  32'(bif.press_idx),   32'h2);

    // Release btn2
    bif.btn_raw = 4'b0000;
    wait_level(4'b0100, 4'b0000, 30, n);
    step();
    chk("rel_pulse",   32'(bif.btn_release), 32'h4);
    chk("rel_novalid", 32'(bif.press_valid), 32'h0);
    chk("rel_idx",     32'(bif.press_idx),   32'h2);
    step();

    // Glitch: 6-cycle pulse on btn1
    clr_seen();
    bif.btn_raw = 4'b0010;
    repeat (6) step();
    bif.btn_raw = 4'b0000;
    repeat (20) step();
    chk("glitch_level", 32'(bif.btn_level), 32'h0);
    chk("glitch_pulse", 32'({seen_press, seen_rel}), 32'h0);

    // Bursts of 10 high / 2 low, phased so each burst spans only 2 ticks
    while ((cyc % 4) != 2) step();
    clr_seen();
    for (int b = 0; b < 4; b++) begin
      bif.btn_raw = 4'b0010;
      repeat (10) step();
      bif.btn_raw = 4'b0000;
      repeat (2) step();
    end
    repeat (20) step();
    chk("burst_level", 32'(bif.btn_level), 32'h0);
    chk("burst_pulse", 32'({seen_press, seen_rel}), 32'h0);

    // Simultaneous press of btn1 and btn3
    bif.btn_raw = 4'b1010;
    wait_level(4'b1010, 4'b1010, 30, n);
    chk("sim_level", 32'(bif.btn_level), 32'ha);
    step();
    chk("sim_press", 32'(bif.btn_press),   32'ha);
    chk("sim_valid", 32'(bif.press_valid), 32'h1);
    chk("sim_idx",   32'(bif.press_idx),   32'h1);
    step();
    chk("sim_once",  32'(bif.btn_press),   32'h0);

    // Simultaneous release keeps press_idx
    bif.btn_raw = 4'b0000;
    wait_level(4'b1010, 4'b0000, 30, n);
    step();
    chk("simrel_pulse", 32'(bif.btn_release), 32'ha);
    chk("simrel_valid", 32'(bif.press_valid), 32'h0);
    chk("simrel_idx",   32'(bif.press_idx),   32'h1);
    step();

    // Reset midway through btn3 qualification, raw held high
    bif.btn_raw = 4'b1000;
    repeat (6) step();
    rst = 1'b1;
    step();
    chk("mid_rst_level",   32'(bif.btn_level),   32'h0);
    chk("mid_rst_press",   32'(bif.btn_press),   32'h0);
    chk("mid_rst_release", 32'(bif.btn_release), 32'h0);
    chk("mid_rst_valid",   32'(bif.press_valid), 32'h0);
    chk("mid_rst_idx",     32'(bif.press_idx),   32'h0);
    rst = 1'b0;
    cyc = 0;
    clr_seen();
    wait_level(4'b1000, 4'b1000, 30, n);
    chk("requal_lat",   32'(n), 32'd12);
    chk("requal_early", 32'(seen_press), 32'h0);
    step();
    chk("requal_press", 32'(bif.btn_press),   32'h8);
    chk("requal_valid", 32'(bif.press_valid), 32'h1);
    chk("requal_idx",   32'(bif.press_idx),   32'h3);

    // Release btn3, then press btn0
    bif.btn_raw = 4'b0000;
    wait_level(4'b1000, 4'b0000, 30, n);
    step();
    step();
    bif.btn_raw = 4'b0001;
    wait_level(4'b0001, 4'b0001, 30, n);
    step();
    chk("b0_press", 32'(bif.btn_press), 32'h1);
    chk("b0_idx",   32'(bif.press_idx), 32'h0);
    step();

    // Release btn0: release pulse without press_valid
    bif.btn_raw = 4'b0000;
    wait_level(4'b0001, 4'b0000, 30, n);
    step();
    chk("b0_rel",     32'(bif.btn_release), 32'h1);
    chk("b0_rel_nv",  32'(bif.press_valid), 32'h0);
    chk("b0_rel_idx", 32'(bif.press_idx),   32'h0);
    step();

    // Press btn3: index moves 0 -> 3
    bif.btn_raw = 4'b1000;
    wait_level(4'b1000, 4'b1000, 30, n);
    step();
    chk("b3_press", 32'(bif.btn_press),   32'h8);
    chk("b3_valid", 32'(bif.press_valid), 32'h1);
    chk("b3_idx",   32'(bif.press_idx),   32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
